fir_coeff_loader: RTL and testbench

Sequencer in front of the adaptive FIR core: owns the core's `x_n`, `s_axis_fir_tvalid` and `s_set_coeffs` inputs. It stores several coefficient banks written by a host port. On request, it pauses the sample stream and shifts the selected bank into the FIR over the shared `x_n` bus, then resumes streaming. Upstream sample sources see a ready/valid handshake, so no sample is lost or duplicated across a reload.

---
 rtl/fir_coeff_loader.sv | 166 ++++++++++++++++
 tb/tb_fir_coeff_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_loader.sv
// Coefficient-bank sequencer for the adaptive FIR: streams samples, or shifts a stored bank over x_n.
// Optional build macro FIR_AUTOLOAD_EN: bank 0 resets to identity and is loaded right after reset.
module fir_coeff_loader #(
    parameter int DW       = 6,
    parameter int NTAPS    = 3,
    parameter int NUM_SETS = 4,
    localparam int BW = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
    localparam int TW = (NTAPS > 1) ? $clog2(NTAPS) : 1,
    localparam int CW = $clog2(NTAPS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [BW-1:0] cfg_bank,
    input  logic [TW-1:0] cfg_tap,
    input  logic [DW-1:0] cfg_data,
    input  logic          load_req,
    input  logic [BW-1:0] load_bank,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    output logic          s_tready,
    output logic [DW-1:0] fir_x_n,
    output logic          fir_tvalid,
    output logic          fir_set_coeffs,
    output logic          busy,
    output logic          load_done,
    output logic          load_err,
    output logic [BW-1:0] active_bank
);

`ifdef FIR_AUTOLOAD_EN
    localparam bit AUTOLOAD = 1'b1;
`else
    localparam bit AUTOLOAD = 1'b0;
`endif

    typedef enum logic [1:0] {ST_PASS, ST_LOAD, ST_GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tap_q, tap_d;
    logic [BW-1:0] bank_q, bank_d;
    logic [BW-1:0] active_q, active_d;
    logic [DW-1:0] x_q, x_d;
    logic          tvalid_q, tvalid_d;
    logic          set_q, set_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          auto_q, auto_d;
    logic          wr_en;

    logic [DW-1:0] mem_q [NUM_SETS][NTAPS];

    assign wr_en = cfg_we && (int'(cfg_bank) < NUM_SETS) && (int'(cfg_tap) < NTAPS);

    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        bank_d   = bank_q;
        active_d = active_q;
        x_d      = x_q;
        tvalid_d = 1'b0;
        set_d    = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        auto_d   = auto_q;
        s_tready = 1'b0;
        unique case (state_q)
            ST_PASS: begin
                if (auto_q) begin
                    auto_d  = 1'b0;
                    state_d = ST_LOAD;
                    bank_d  = '0;
                    x_d     = mem_q[0][0];
                    set_d   = 1'b1;
                    tap_d   = CW'(1);
                end else if (load_req) begin
                    if (int'(load_bank) < NUM_SETS) begin
                        state_d = ST_LOAD;
                        bank_d  = load_bank;
                        x_d     = mem_q[load_bank][0];
                        set_d   = 1'b1;
                        tap_d   = CW'(1);
                    end else begin
                        err_d = 1'b1;
                        x_d   = s_tdata;
                    end
                end else begin
                    s_tready = 1'b1;
                    x_d      = s_tdata;
                    tvalid_d = s_tvalid;
                end
            end
            ST_LOAD: begin
                err_d = load_req;
                if (tap_q == CW'(NTAPS)) begin
                    // A rejected request coinciding with completion is dropped so done/err never overlap.
                    err_d    = 1'b0;
                    state_d  = ST_GAP;
                    done_d   = 1'b1;
                    active_d = bank_q;
                    x_d      = '0;
                end else begin
                    x_d   = mem_q[bank_q][tap_q[TW-1:0]];
                    set_d = 1'b1;
                    tap_d = tap_q + CW'(1);
                end
            end
            ST_GAP: begin
                err_d   = load_req;
                state_d = ST_PASS;
                x_d     = '0;
            end
            default: state_d = ST_PASS;
        endcase
        busy_d = (state_d != ST_PASS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_PASS;
            tap_q    <= '0;
            bank_q   <= '0;
            active_q <= '0;
            x_q      <= '0;
            tvalid_q <= 1'b0;
            set_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            auto_q   <= AUTOLOAD;
            for (int unsigned b = 0; b < NUM_SETS; b++) begin
                for (int unsigned t = 0; t < NTAPS; t++) begin
                    mem_q[b][t] <= '0;
                end
            end
`ifdef FIR_AUTOLOAD_EN
            mem_q[0][0] <= DW'(1);
`endif
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            bank_q   <= bank_d;
            active_q <= active_d;
            x_q      <= x_d;
            tvalid_q <= tvalid_d;
            set_q    <= set_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            auto_q   <= auto_d;
            if (wr_en) begin
                mem_q[cfg_bank][cfg_tap] <= cfg_data;
            end
        end
    end

    assign fir_x_n        = x_q;
    assign fir_tvalid     = tvalid_q;
    assign fir_set_coeffs = set_q;
    assign busy           = busy_q;
    assign load_done      = done_q;
    assign load_err       = err_q;
    assign active_bank    = active_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed self-checking bench for fir_coeff_loader (3 banks so an out-of-range bank is encodable).
module tb_fir_coeff_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [1:0] cfg_bank, cfg_tap, load_bank, active_bank;
    logic [5:0] cfg_data, s_tdata, fir_x_n;
    logic       load_req, s_tvalid, s_tready;
    logic       fir_tvalid, fir_set_coeffs, busy, load_done, load_err;

    int checks   = 0;
    int failures = 0;

    fir_coeff_loader #(.DW(6), .NTAPS(3), .NUM_SETS(3)) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_bank(cfg_bank), .cfg_tap(cfg_tap), .cfg_data(cfg_data),
        .load_req(load_req), .load_bank(load_bank),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .fir_x_n(fir_x_n), .fir_tvalid(fir_tvalid), .fir_set_coeffs(fir_set_coeffs),
        .busy(busy), .load_done(load_done), .load_err(load_err), .active_bank(active_bank)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] b, input logic [1:0] t, input logic [5:0] d);
        cfg_we = 1'b1; cfg_bank = b; cfg_tap = t; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; cfg_we = 1'b0; cfg_bank = '0; cfg_tap = '0; cfg_data = '0;
        load_req = 1'b0; load_bank = '0; s_tdata = '0; s_tvalid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++; if (fir_x_n !== 6'd0) begin failures++; $display("FAIL rst_x got=%0d exp=0", fir_x_n); end
        checks++; if (fir_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%b exp=0", fir_tvalid); end
        checks++; if (fir_set_coeffs !== 1'b0) begin failures++; $display("FAIL rst_set got=%b exp=0", fir_set_coeffs); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (load_done !== 1'b0 || load_err !== 1'b0) begin failures++; $display("FAIL rst_pulses got=%b%b exp=00", load_done, load_err); end
        checks++; if (active_bank !== 2'd0) begin failures++; $display("FAIL rst_active got=%0d exp=0", active_bank); end
        checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL rst_tready got=%b exp=1", s_tready); end
    endtask

    task automatic test_stream;
        for (int i = 1; i <= 3; i++) begin
            s_tdata = 6'(i); s_tvalid = 1'b1;
            #1;
            checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL stream_tready[%0d] got=%b exp=1", i, s_tready); end
            tick();
            checks++; if (fir_x_n !== 6'(i)) begin failures++; $display("FAIL stream_x[%0d] got=%0d exp=%0d", i, fir_x_n, i); end
            checks++; if (fir_tvalid !== 1'b1) begin failures++; $display("FAIL stream_tvalid[%0d] got=%b exp=1", i, fir_tvalid); end
            checks++; if (fir_set_coeffs !== 1'b0) begin failures++; $display("FAIL stream_set[%0d] got=%b exp=0", i, fir_set_coeffs); end
        end
        s_tvalid = 1'b0;
        tick();
        checks++; if (fir_tvalid !== 1'b0) begin failures++; $display("FAIL stream_idle got=%b exp=0", fir_tvalid); end
    endtask

    task automatic test_load;
        logic [5:0] ex_x [3];
        logic       ex_set [5];
        logic       ex_done [5];
        logic       ex_busy [5];
        ex_x = '{6'b000111, 6'b111011, 6'b011011};
        ex_set = '{1, 1, 1, 0, 0};
        ex_done = '{0, 0, 0, 1, 0};
        ex_busy = '{1, 1, 1, 1, 0};
        wr(2'd2, 2'd0, 6'b000111);
        wr(2'd2, 2'd1, 6'b111011);
        wr(2'd2, 2'd2, 6'b011011);
        s_tvalid = 1'b1; s_tdata = 6'd40;
        load_req = 1'b1; load_bank = 2'd2;
        #1;
        checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL load_req_tready got=%b exp=0", s_tready); end
        tick();
        load_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++; if (fir_set_coeffs !== ex_set[c]) begin failures++; $display("FAIL load_set[%0d] got=%b exp=%b", c, fir_set_coeffs, ex_set[c]); end
            if (c < 3) begin
                checks++; if (fir_x_n !== ex_x[c]) begin failures++; $display("FAIL load_x[%0d] got=%0d exp=%0d", c, fir_x_n, ex_x[c]); end
            end
            checks++; if (load_done !== ex_done[c]) begin failures++; $display("FAIL load_done[%0d] got=%b exp=%b", c, load_done, ex_done[c]); end
            checks++; if (busy !== ex_busy[c]) begin failures++; $display("FAIL load_busy[%0d] got=%b exp=%b", c, busy, ex_busy[c]); end
            checks++; if (c < 4 && fir_tvalid !== 1'b0) begin failures++; $display("FAIL load_tvalid[%0d] got=%b exp=0", c, fir_tvalid); end
            if (c < 4) tick();
        end
        checks++; if (active_bank !== 2'd2) begin failures++; $display("FAIL load_active got=%0d exp=2", active_bank); end
        checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL load_resume_tready got=%b exp=1", s_tready); end
        s_tvalid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [5:0] cnt = 6'd1;
        logic [5:0] exp_next = 6'd1;
        int         stall = 0;
        logic       acc;
        for (int i = 0; i < 16; i++) begin
            s_tdata = cnt; s_tvalid = 1'b1;
            load_req = (i == 4); load_bank = 2'd2;
            #1;
            acc = s_tready;
            if (!s_tready) stall++;
            tick();
            load_req = 1'b0;
            if (acc) cnt = cnt + 6'd1;
            if (fir_tvalid) begin
                checks++; if (fir_x_n !== exp_next) begin failures++; $display("FAIL b2b_seq got=%0d exp=%0d", fir_x_n, exp_next); end
                exp_next = exp_next + 6'd1;
            end
        end
        s_tvalid = 1'b0;
        tick();
        checks++; if (stall !== 5) begin failures++; $display("FAIL b2b_stall got=%0d exp=5", stall); end
        checks++; if (exp_next !== cnt) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", exp_next, cnt); end
    endtask

    task automatic test_errors;
        s_tvalid = 1'b1; s_tdata = 6'd50;
        load_req = 1'b1; load_bank = 2'd3;
        #1;
        checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL err_bad_tready got=%b exp=0", s_tready); end
        tick();
        load_req = 1'b0; s_tvalid = 1'b0;
        checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL err_bad_pulse got=%b exp=1", load_err); end
        checks++; if (busy !== 1'b0 || fir_set_coeffs !== 1'b0) begin failures++; $display("FAIL err_bad_noload got=%b%b exp=00", busy, fir_set_coeffs); end
        checks++; if (fir_tvalid !== 1'b0) begin failures++; $display("FAIL err_bad_tvalid got=%b exp=0", fir_tvalid); end
        tick();
        checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL err_bad_single got=%b exp=0", load_err); end
        load_req = 1'b1; load_bank = 2'd2;
        tick();
        load_bank = 2'd0;
        tick();
        load_req = 1'b0;
        checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL err_inload_pulse got=%b exp=1", load_err); end
        checks++; if (fir_set_coeffs !== 1'b1 || fir_x_n !== 6'b111011) begin failures++; $display("FAIL err_inload_tap1 got=%b/%0d exp=1/%0d", fir_set_coeffs, fir_x_n, 6'b111011); end
        tick();
        checks++; if (fir_x_n !== 6'b011011) begin failures++; $display("FAIL err_inload_tap2 got=%0d exp=%0d", fir_x_n, 6'b011011); end
        tick();
        checks++; if (load_done !== 1'b1 || active_bank !== 2'd2) begin failures++; $display("FAIL err_inload_done got=%b/%0d exp=1/2", load_done, active_bank); end
        tick();
    endtask

    task automatic test_live_write;
        load_req = 1'b1; load_bank = 2'd2;
        cfg_we = 1'b1; cfg_bank = 2'd2; cfg_tap = 2'd0; cfg_data = 6'd9;
        tick();
        load_req = 1'b0;
        checks++; if (fir_x_n !== 6'b000111) begin failures++; $display("FAIL live_tap0_old got=%0d exp=7", fir_x_n); end
        cfg_tap = 2'd2; cfg_data = 6'd3;
        tick();
        cfg_we = 1'b0;
        checks++; if (fir_x_n !== 6'b111011) begin failures++; $display("FAIL live_tap1 got=%0d exp=%0d", fir_x_n, 6'b111011); end
        tick();
        checks++; if (fir_x_n !== 6'd3) begin failures++; $display("FAIL live_tap2_new got=%0d exp=3", fir_x_n); end
        tick(); tick();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        checks++; if (fir_x_n !== 6'd9) begin failures++; $display("FAIL live_reload_tap0 got=%0d exp=9", fir_x_n); end
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_reset_mid_load;
        load_req = 1'b1; load_bank = 2'd2;
        tick();
        load_req = 1'b0;
        tick();
        checks++; if (fir_set_coeffs !== 1'b1 || fir_x_n !== 6'b111011) begin failures++; $display("FAIL rml_tap1 got=%b/%0d exp=1/%0d", fir_set_coeffs, fir_x_n, 6'b111011); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (fir_set_coeffs !== 1'b0) begin failures++; $display("FAIL rml_set got=%b exp=0", fir_set_coeffs); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rml_busy got=%b exp=0", busy); end
        checks++; if (fir_x_n !== 6'd0 || active_bank !== 2'd0) begin failures++; $display("FAIL rml_regs got=%0d/%0d exp=0/0", fir_x_n, active_bank); end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (load_done !== 1'b0 || fir_set_coeffs !== 1'b0) begin failures++; $display("FAIL rml_nodone[%0d] got=%b%b exp=00", c, load_done, fir_set_coeffs); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_load();
        test_back_to_back();
        test_errors();
        test_live_write();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
